// File: rtl/mips32_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : mips32_prog_loader_if
// Brief    : Byte-stream input and instruction-memory write bus of the loader.
// Revision : 1.0
// ============================================================================
interface mips32_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    // master: byte source plus instruction memory; slave: the loader itself
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mips32_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : mips32_prog_loader
// Brief    : Loads a counted big-endian word stream into instruction memory,
//            then releases the CPU with a single start pulse.
// Revision : 1.0
// ============================================================================
module mips32_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  wire                  clk1,
    input  wire                  rst_n,
    mips32_prog_loader_if.slave  bus,
    output logic                 cpu_halt,
    output logic                 cpu_start,
    output logic                 load_err
);

    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam int                c_cap  = (1 << ADDR_W) - BASE_ADDR;
    localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);

    state_t            r_state;
    state_t            w_next;
    logic              r_active;
    logic              r_started;
    logic [7:0]        r_n_msb;
    logic [15:0]       r_n;
    logic [ADDR_W:0]   r_count;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_asm;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              w_xfer;
    logic [15:0]       w_n_full;
    logic              w_n_bad;
    logic [ADDR_W:0]   w_count_inc;
    logic              w_more;

    assign w_xfer      = bus.in_valid && bus.in_ready;
    assign w_n_full    = {r_n_msb, bus.in_data};
    assign w_n_bad     = (w_n_full == 16'd0) || (32'(w_n_full) > 32'(c_cap));
    assign w_count_inc = r_count + 1'b1;
    assign w_more      = 32'(w_count_inc) < 32'(r_n);

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        cpu_halt      = 1'b1;
        cpu_start     = 1'b0;
        load_err      = 1'b0;
        case (r_state)
            HDR0: begin
                bus.in_ready = r_active;
                if (w_xfer) w_next = HDR1;
            end
            HDR1: begin
                bus.in_ready = r_active;
                if (w_xfer) w_next = w_n_bad ? ERR : DATA;
            end
            DATA: begin
                bus.in_ready = r_active;
                if (w_xfer && r_byte_idx == 2'd3) w_next = WRITE;
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                w_next     = w_more ? DATA : DONE;
            end
            DONE: begin
                cpu_halt  = 1'b0;
                cpu_start = !r_started;
            end
            ERR: begin
                load_err = 1'b1;
            end
            default: w_next = HDR0;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_state    <= HDR0;
            r_active   <= 1'b0;
            r_started  <= 1'b0;
            r_n_msb    <= 8'd0;
            r_n        <= 16'd0;
            r_count    <= '0;
            r_byte_idx <= 2'd0;
            r_asm      <= 24'd0;
            r_addr     <= c_base;
            r_wdata    <= 32'd0;
        end else begin
            r_state  <= w_next;
            r_active <= 1'b1;
            if (r_state == DONE) r_started <= 1'b1;
            if (w_xfer) begin
                case (r_state)
                    HDR0: r_n_msb <= bus.in_data;
                    HDR1: begin
                        r_n        <= w_n_full;
                        r_count    <= '0;
                        r_byte_idx <= 2'd0;
                    end
                    DATA: begin
                        r_byte_idx <= r_byte_idx + 1'b1;
                        r_asm      <= {r_asm[15:0], bus.in_data};
                        // last byte goes straight to the write register so the word is out next cycle
                        if (r_byte_idx == 2'd3) begin
                            r_wdata <= {r_asm, bus.in_data};
                            r_addr  <= c_base + r_count[ADDR_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end
            if (r_state == WRITE) r_count <= w_count_inc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips32_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips32_prog_loader
// Brief    : Randomized scoreboard bench for the program loader (two sizes).
// Revision : 1.0
// ============================================================================
module tb_mips32_prog_loader;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic       rst_n = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'd0;
    logic       sel   = 1'b0;
    logic       halt_a, start_a, err_a, halt_b, start_b, err_b;
    logic       rdy;

    mips32_prog_loader_if #(.ADDR_W(10)) bus_a ();
    mips32_prog_loader_if #(.ADDR_W(4))  bus_b ();

    assign bus_a.in_valid = valid & ~sel;
    assign bus_a.in_data  = data;
    assign bus_b.in_valid = valid & sel;
    assign bus_b.in_data  = data;
    assign rdy = sel ? bus_b.in_ready : bus_a.in_ready;

    mips32_prog_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut_a (
        .clk1(clk1), .rst_n(rst_n), .bus(bus_a),
        .cpu_halt(halt_a), .cpu_start(start_a), .load_err(err_a)
    );

    mips32_prog_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut_b (
        .clk1(clk1), .rst_n(rst_n), .bus(bus_b),
        .cpu_halt(halt_b), .cpu_start(start_b), .load_err(err_b)
    );

    typedef struct {
        bit          b;
        bit          start;
        int          addr;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic sb_event(input bit b, input bit st, input int addr, input logic [31:0] w);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: dut=%0d start=%0d addr=%0d data=%h, required none", b, st, addr, w);
            return;
        end
        e = exp_q.pop_front();
        chk("event_dut", 32'(b), 32'(e.b));
        chk("event_kind", 32'(st), 32'(e.start));
        if (!st) begin
            chk("write_addr", addr, e.addr);
            chk("write_data", w, e.word);
        end
    endtask

    // monitor: pops the scoreboard on every write strobe or start pulse
    logic        prev_start_a = 1'b0, prev_start_b = 1'b0, prev_rst = 1'b0;
    logic [9:0]  prev_addr;
    logic [31:0] prev_wdata;
    always @(negedge clk1) begin
        if (bus_a.mem_we === 1'b1) begin
            sb_event(1'b0, 1'b0, int'(bus_a.mem_addr), bus_a.mem_wdata);
            chk("ready_low_in_write", 32'(bus_a.in_ready), 32'd0);
        end
        if (bus_b.mem_we === 1'b1) sb_event(1'b1, 1'b0, int'(bus_b.mem_addr), bus_b.mem_wdata);
        if (start_a === 1'b1) begin
            chk("start_single_a", 32'(prev_start_a), 32'd0);
            sb_event(1'b0, 1'b1, 0, 32'd0);
        end
        if (start_b === 1'b1) begin
            chk("start_single_b", 32'(prev_start_b), 32'd0);
            sb_event(1'b1, 1'b1, 0, 32'd0);
        end
        if (rst_n === 1'b1 && prev_rst === 1'b1 && bus_a.mem_we === 1'b0) begin
            chk("addr_hold", 32'(bus_a.mem_addr), 32'(prev_addr));
            chk("wdata_hold", bus_a.mem_wdata, prev_wdata);
        end
        prev_start_a = start_a;
        prev_start_b = start_b;
        prev_rst     = rst_n;
        prev_addr    = bus_a.mem_addr;
        prev_wdata   = bus_a.mem_wdata;
    end

    // reference model: a legal load yields N ordered writes then one start
    function automatic bit model_load(input bit b, input int n, input logic [31:0] words[$]);
        int cap = b ? 16 : 1024;
        if (n == 0 || n > cap) return 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back('{b, 1'b0, i, words[i]});
        exp_q.push_back('{b, 1'b1, 0, 32'd0});
        return 1'b0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int t = 0;
        if (stall) begin
            while ($urandom_range(1, 0) == 1) begin
                valid = 1'b0;
                data  = 8'($urandom);
                @(negedge clk1);
            end
        end
        valid = 1'b1;
        data  = b;
        while (rdy !== 1'b1) begin
            @(negedge clk1);
            t++;
            if (t > 50) begin
                n_total++;
                $display("FAIL send_timeout: in_ready=%b, required 1", rdy);
                valid = 1'b0;
                return;
            end
        end
        @(negedge clk1);
        valid = 1'b0;
        data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        send_byte(w[31:24], stall);
        send_byte(w[23:16], stall);
        send_byte(w[15:8], stall);
        send_byte(w[7:0], stall);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk1);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d events pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk1);
    endtask

    task automatic offer_refused(input int k);
        for (int i = 0; i < k; i++) begin
            valid = 1'b1;
            data  = 8'($urandom);
            chk("refused_ready", 32'(rdy), 32'd0);
            @(negedge clk1);
        end
        valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (2) @(negedge clk1);
        chk("rst_ready", 32'(bus_a.in_ready), 32'd0);
        chk("rst_we", 32'(bus_a.mem_we), 32'd0);
        chk("rst_addr", 32'(bus_a.mem_addr), 32'd0);
        chk("rst_wdata", bus_a.mem_wdata, 32'd0);
        chk("rst_halt", 32'(halt_a), 32'd1);
        chk("rst_start", 32'(start_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk1);
        chk("ready_after_reset", 32'(bus_a.in_ready), 32'd1);
    endtask

    task automatic run_load(input bit b, input int n, input logic [31:0] words[$], input bit stall);
        bit e;
        sel = b;
        e = model_load(b, n, words);
        send_byte(8'(n >> 8), stall);
        send_byte(8'(n), stall);
        if (!e) foreach (words[i]) send_word(words[i], stall);
        wait_drain();
        chk("final_err", 32'(b ? err_b : err_a), 32'(e));
        chk("final_halt", 32'(b ? halt_b : halt_a), 32'(e));
        chk("final_start", 32'(b ? start_b : start_a), 32'd0);
        offer_refused(4);
        chk("halt_stable", 32'(b ? halt_b : halt_a), 32'(e));
        chk("err_stable", 32'(b ? err_b : err_a), 32'(e));
    endtask

    initial begin
        logic [31:0] prog[$];
        logic [31:0] w[$];
        int          n;

        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h00222000,
                 32'h0ce77800, 32'h00832800, 32'hfc000000};

        do_reset();
        run_load(1'b0, 7, prog, 1'b0);
        do_reset();
        run_load(1'b0, 7, prog, 1'b1);

        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(12, 1);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom);
            do_reset();
            run_load(1'b0, n, w, k[0]);
        end

        w.delete();
        do_reset();
        run_load(1'b0, 0, w, 1'b0);
        do_reset();
        run_load(1'b0, 1025, w, 1'b1);

        do_reset();
        run_load(1'b1, 17, w, 1'b0);
        for (int i = 0; i < 16; i++) w.push_back($urandom);
        do_reset();
        run_load(1'b1, 16, w, 1'b1);

        // reset mid-load: three words land, the half-sent fourth is dropped
        do_reset();
        sel = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, 1'b0, i, prog[i]});
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        for (int i = 0; i < 3; i++) send_word(prog[i], 1'b1);
        send_byte(prog[3][31:24], 1'b0);
        send_byte(prog[3][23:16], 1'b0);
        wait_drain();
        do_reset();
        run_load(1'b0, 1, '{32'hdeadbeef}, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mips32_prog_loader.md
MIPS32_PROG_LOADER -- requirements
Module: mips32_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of instruction memory (depth 2^ADDR_W words).
REQ-002 SHALL have parameter BASE_ADDR, default 0, first word address written.
REQ-003 SHALL have port clk1  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  byte-stream source has a byte.
REQ-006 SHALL have port in_data  input  8  stream byte.
REQ-007 SHALL have port in_ready  output  1  loader accepts byte; a transfer occurs when in_valid && in_ready.
REQ-008 SHALL have port mem_we  output  1  one-cycle word write strobe to instruction memory.
REQ-009 SHALL have port mem_addr  output  ADDR_W  word address of the write.
REQ-010 SHALL have port mem_wdata  output  32  instruction word.
REQ-011 SHALL have port cpu_halt  output  1  holds the CPU halted while high.
REQ-012 SHALL have port cpu_start  output  1  one-cycle pulse: CPU clears PC and TAKEN_BRANCH and starts.
REQ-013 SHALL have port load_err  output  1  sticky error flag.

Function
REQ-014 SHALL use states HDR0, HDR1, DATA, WRITE, DONE, ERR.
REQ-015 Stream format SHALL be a 16-bit word count N (big-endian: HDR0 takes the MSB, HDR1 takes the LSB), then N words of 4 bytes each, MSB first.
REQ-016 in_ready SHALL be 1 in HDR0, HDR1 and DATA, and 0 in WRITE, DONE and ERR.
REQ-017 In HDR1, on a transfer: if N==0 or N>2^ADDR_W-BASE_ADDR, the next state SHALL be ERR; otherwise it SHALL be DATA, with word counter=0 and byte index=0.
REQ-018 In DATA, each transfer SHALL shift the byte into a 32-bit assembly register (byte 0 lands in bits 31:24) and increment a 2-bit byte index.
REQ-019 On the 4th byte transfer, the next state SHALL be WRITE; the assembled word SHALL appear on mem_wdata with mem_we=1 for exactly that one WRITE cycle, and mem_addr SHALL be BASE_ADDR+word counter.
REQ-020 After WRITE, the word counter SHALL increment; the next state SHALL be DATA if the counter is below N, else DONE.
REQ-021 Byte-to-write latency SHALL be one cycle after the 4th byte handshake; sustained throughput SHALL be 4 bytes per 5 cycles.
REQ-022 in_valid low SHALL stall without loss; in_data SHALL be ignored when no transfer occurs.
REQ-023 On entry to DONE: cpu_start=1 for exactly the first DONE cycle, and cpu_halt=0 from that cycle on; DONE SHALL persist until reset.
REQ-024 In ERR: load_err=1, cpu_halt=1, cpu_start=0, mem_we=0; ERR SHALL persist until reset.
REQ-025 mem_we SHALL never be high outside WRITE; mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-026 The word counter SHALL be ADDR_W+1 bits wide; no address wrap SHALL occur, since REQ-017 bounds N.
REQ-027 Bytes offered after DONE or ERR SHALL be refused (in_ready=0).

Reset
REQ-028 With rst_n=0 sampled on a clk1 edge: state=HDR0, in_ready=0 during reset, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_halt=1, cpu_start=0, load_err=0, counters=0.
REQ-029 Reset mid-load SHALL discard any partial word and header; memory already written SHALL NOT be cleared; the next load SHALL restart at HDR0.
REQ-030 in_ready SHALL rise in the first cycle after rst_n is sampled high.

Verification
REQ-031 Stream 00 07 then 2801000a, 28020014, 28030019, 00222000, 0ce77800, 00832800, fc000000 -> seven mem_we pulses at addresses 0..6 with exactly those words, then one cpu_start pulse, cpu_halt=0, load_err=0.
REQ-032 Same stream with in_valid toggled randomly (~50% duty) -> identical writes in identical order, no duplicates, single cpu_start.
REQ-033 Header 00 00 -> ERR; load_err=1, no mem_we, cpu_halt stays 1, in_ready=0; also with ADDR_W=4, header 00 11 (17) -> ERR, while header 00 10 (16) -> 16 writes at addresses 0..15, then DONE.
REQ-034 rst_n pulsed low after 2 of 4 bytes of word 3 -> no write for word 3; a reload of N=1, word deadbeef -> single write at address 0, then cpu_start.
REQ-035 Bytes offered in WRITE, DONE and ERR -> in_ready=0, no state or output change; cpu_start is never high for more than one cycle.
